vga_screen_mux: RTL and testbench

//  Parametrised successor to the per-state screen select in the VGA top level.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/rgb_scale.sv | 17 +
 rtl/vga_screen_mux.sv | 155 +++++++++++++++
 tb/tb_vga_screen_mux.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA types and widths used by the screen mux and its scaler.
package vga_pkg;

  localparam int unsigned RGB_W     = 12;
  localparam int unsigned COUNT_W   = 11;
  localparam int unsigned LEVEL_MAX = 16;
  localparam int unsigned LEVEL_W   = 5;

  typedef enum logic [1:0] {IDLE, PENDING, FADE_OUT, FADE_IN} screen_mux_state_t;

  typedef struct packed {
    logic [COUNT_W-1:0] hcount;
    logic [COUNT_W-1:0] vcount;
    logic               hsync;
    logic               vsync;
    logic               hblnk;
    logic               vblnk;
  } vga_timing_t;

endpackage

// File: rtl/rgb_scale.sv
// Combinational per-component brightness scaler: c_out = (c * level) >> 4.
module rgb_scale
  import vga_pkg::*;
(
  input  logic [RGB_W-1:0]   i_rgb,
  input  logic [LEVEL_W-1:0] i_level,
  output logic [RGB_W-1:0]   o_rgb_c
);

  always_comb begin
    o_rgb_c = '0;
    for (int i = 0; i < 3; i++) begin
      o_rgb_c[4*i +: 4] = 4'((9'(i_rgb[4*i +: 4]) * 9'(i_level)) >> 4);
    end
  end

endmodule

// File: rtl/vga_screen_mux.sv
// Frame-synchronous screen selector with optional fade through black; fixed
// two-cycle latency on pixel and timing outputs.
module vga_screen_mux
  import vga_pkg::*;
#(
  parameter int unsigned N_SCREENS    = 4,
  parameter int unsigned SEL_W        = 2,
  parameter int unsigned RESET_SCREEN = 0,
  parameter bit          FADE_EN      = 1'b1,
  parameter int unsigned FADE_STEP    = 4
) (
  input  logic                       pclk,
  input  logic                       rst,
  input  logic [SEL_W-1:0]           screen_req,
  input  logic                       screen_req_valid,
  input  logic [N_SCREENS*RGB_W-1:0] rgb_in,
  input  logic [COUNT_W-1:0]         hcount_in,
  input  logic [COUNT_W-1:0]         vcount_in,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic                       hblnk_in,
  input  logic                       vblnk_in,
  output logic [COUNT_W-1:0]         hcount_out,
  output logic [COUNT_W-1:0]         vcount_out,
  output logic                       hsync_out,
  output logic                       vsync_out,
  output logic                       hblnk_out,
  output logic                       vblnk_out,
  output logic [RGB_W-1:0]           rgb_out,
  output logic [SEL_W-1:0]           screen_active,
  output logic                       switch_busy,
  output logic                       req_error
);

  localparam logic [LEVEL_W:0]   STEP_X  = (LEVEL_W+1)'(FADE_STEP);
  localparam logic [LEVEL_W:0]   MAX_X   = (LEVEL_W+1)'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] LVL_MAX = LEVEL_W'(LEVEL_MAX);

  screen_mux_state_t  r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_active, w_active_nxt;
  logic [SEL_W-1:0]   r_target, w_target_nxt;
  logic [LEVEL_W-1:0] r_level, w_level_nxt;
  logic [LEVEL_W-1:0] w_lvl_dn, w_lvl_up;
  logic [LEVEL_W:0]   w_lvl_x, w_lvl_sum;
  logic               r_vblnk_d, w_frame_tick, w_req_ok;
  logic               r_busy, r_req_error;
  vga_timing_t        w_tim_in, r_s1_tim, r_s2_tim;
  logic [RGB_W-1:0]   w_rgb_sel, r_s1_rgb, w_rgb_scaled, r_rgb_out;

  assign w_frame_tick = vblnk_in & ~r_vblnk_d;
  assign w_req_ok     = screen_req_valid && (32'(screen_req) < N_SCREENS);
  assign w_target_nxt = w_req_ok ? screen_req : r_target;

  // Saturating level arithmetic, one bit wider to avoid wrap.
  assign w_lvl_x   = {1'b0, r_level};
  assign w_lvl_sum = w_lvl_x + STEP_X;
  assign w_lvl_dn  = (w_lvl_x > STEP_X) ? LEVEL_W'(w_lvl_x - STEP_X) : '0;
  assign w_lvl_up  = (w_lvl_sum >= MAX_X) ? LVL_MAX : LEVEL_W'(w_lvl_sum);

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_active    <= SEL_W'(RESET_SCREEN);
      r_target    <= SEL_W'(RESET_SCREEN);
      r_level     <= LVL_MAX;
      r_vblnk_d   <= 1'b0;
      r_busy      <= 1'b0;
      r_req_error <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_active    <= w_active_nxt;
      r_target    <= w_target_nxt;
      r_level     <= w_level_nxt;
      r_vblnk_d   <= vblnk_in;
      r_busy      <= (w_state_nxt != IDLE);
      r_req_error <= screen_req_valid & ~w_req_ok;
    end
  end

  // Leaving PENDING already takes the first fade step so the fade is symmetric.
  always_comb begin
    w_state_nxt  = r_state;
    w_active_nxt = r_active;
    w_level_nxt  = r_level;
    case (r_state)
      IDLE: begin
        if (w_target_nxt != r_active) w_state_nxt = PENDING;
      end
      PENDING, FADE_OUT: begin
        if (w_frame_tick) begin
          if (!FADE_EN) begin
            w_active_nxt = r_target;
            w_state_nxt  = IDLE;
          end else begin
            w_level_nxt = w_lvl_dn;
            w_state_nxt = FADE_OUT;
            if (w_lvl_dn == '0) begin
              w_active_nxt = r_target;
              w_state_nxt  = FADE_IN;
            end
          end
        end
      end
      FADE_IN: begin
        if (w_frame_tick) begin
          w_level_nxt = w_lvl_up;
          if (w_lvl_up == LVL_MAX) w_state_nxt = (r_target != r_active) ? PENDING : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_rgb_sel = '0;
    for (int k = 0; k < int'(N_SCREENS); k++) begin
      if (r_active == SEL_W'(k)) w_rgb_sel = rgb_in[k*RGB_W +: RGB_W];
    end
  end

  assign w_tim_in = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};

  rgb_scale u_rgb_scale (
    .i_rgb   (r_s1_rgb),
    .i_level (r_level),
    .o_rgb_c (w_rgb_scaled)
  );

  // Stage 1 selects, stage 2 scales and blanks.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_s1_tim  <= '0;
      r_s1_rgb  <= '0;
      r_s2_tim  <= '0;
      r_rgb_out <= '0;
    end else begin
      r_s1_tim  <= w_tim_in;
      r_s1_rgb  <= w_rgb_sel;
      r_s2_tim  <= r_s1_tim;
      r_rgb_out <= (r_s1_tim.hblnk | r_s1_tim.vblnk) ? '0 : w_rgb_scaled;
    end
  end

  assign hcount_out    = r_s2_tim.hcount;
  assign vcount_out    = r_s2_tim.vcount;
  assign hsync_out     = r_s2_tim.hsync;
  assign vsync_out     = r_s2_tim.vsync;
  assign hblnk_out     = r_s2_tim.hblnk;
  assign vblnk_out     = r_s2_tim.vblnk;
  assign rgb_out       = r_rgb_out;
  assign screen_active = r_active;
  assign switch_busy   = r_busy;
  assign req_error     = r_req_error;

endmodule

// File: tb/tb_vga_screen_mux.sv
// Directed bench: a hard-cut and a fading instance share one small raster.
module tb_vga_screen_mux;

  logic        pclk = 1'b0;
  logic        rst;
  logic [47:0] rgb_in;
  logic [10:0] hc_in, vc_in;
  logic        hs_in, vs_in, hb_in, vb_in;
  logic [1:0]  req_c;
  logic        val_c;
  logic [2:0]  req_f;
  logic        val_f;

  logic [10:0] hco_c, vco_c, hco_f, vco_f;
  logic        hso_c, vso_c, hbo_c, vbo_c, hso_f, vso_f, hbo_f, vbo_f;
  logic [11:0] rgb_c, rgb_f;
  logic [1:0]  act_c;
  logic [2:0]  act_f;
  logic        busy_c, busy_f, err_c, err_f;

  typedef struct {
    logic [25:0] tim;
    logic [11:0] rgb_c;
    logic [11:0] rgb_f;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  gpos = 0;
  int  exp_scr_c, exp_scr_f, exp_lvl_f;
  int  lvls [8] = '{12, 8, 4, 0, 4, 8, 12, 16};

  always #5 pclk = ~pclk;

  vga_screen_mux #(.N_SCREENS(4), .SEL_W(2), .RESET_SCREEN(0), .FADE_EN(1'b0), .FADE_STEP(4)) u_cut (
    .pclk(pclk), .rst(rst), .screen_req(req_c), .screen_req_valid(val_c), .rgb_in(rgb_in),
    .hcount_in(hc_in), .vcount_in(vc_in), .hsync_in(hs_in), .vsync_in(vs_in),
    .hblnk_in(hb_in), .vblnk_in(vb_in),
    .hcount_out(hco_c), .vcount_out(vco_c), .hsync_out(hso_c), .vsync_out(vso_c),
    .hblnk_out(hbo_c), .vblnk_out(vbo_c), .rgb_out(rgb_c),
    .screen_active(act_c), .switch_busy(busy_c), .req_error(err_c)
  );

  vga_screen_mux #(.N_SCREENS(4), .SEL_W(3), .RESET_SCREEN(0), .FADE_EN(1'b1), .FADE_STEP(4)) u_fade (
    .pclk(pclk), .rst(rst), .screen_req(req_f), .screen_req_valid(val_f), .rgb_in(rgb_in),
    .hcount_in(hc_in), .vcount_in(vc_in), .hsync_in(hs_in), .vsync_in(vs_in),
    .hblnk_in(hb_in), .vblnk_in(vb_in),
    .hcount_out(hco_f), .vcount_out(vco_f), .hsync_out(hso_f), .vsync_out(vso_f),
    .hblnk_out(hbo_f), .vblnk_out(vbo_f), .rgb_out(rgb_f),
    .screen_active(act_f), .switch_busy(busy_f), .req_error(err_f)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] chan(input int i);
    logic [47:0] all;
    all = rgb_in;
    return all[i*12 +: 12];
  endfunction

  function automatic logic [11:0] scale(input logic [11:0] c, input int lvl);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) r[i*4 +: 4] = 4'((int'(c[i*4 +: 4]) * lvl) >> 4);
    return r;
  endfunction

  // One pixel: 16x8 raster, active h<10 and v<6, vblank starts at position 96.
  task automatic step(input logic vc, input logic [1:0] rc, input logic vf, input logic [2:0] rf);
    sb_t e;
    int  h, v;
    h = gpos % 16;
    v = gpos / 16;
    hc_in = 11'(h);
    vc_in = 11'(v);
    hb_in = (h >= 10);
    vb_in = (v >= 6);
    hs_in = (h == 12) || (h == 13);
    vs_in = (v == 6);
    req_c = rc; val_c = vc; req_f = rf; val_f = vf;
    e.tim   = {hc_in, vc_in, hs_in, vs_in, hb_in, vb_in};
    e.rgb_c = (hb_in | vb_in) ? 12'h000 : chan(exp_scr_c);
    e.rgb_f = (hb_in | vb_in) ? 12'h000 : scale(chan(exp_scr_f), exp_lvl_f);
    sb.push_back(e);
    gpos = (gpos + 1) % 128;
    @(negedge pclk);
    if (sb.size() == 2) begin
      e = sb.pop_front();
      check("timing_cut",  32'({hco_c, vco_c, hso_c, vso_c, hbo_c, vbo_c}), 32'(e.tim));
      check("timing_fade", 32'({hco_f, vco_f, hso_f, vso_f, hbo_f, vbo_f}), 32'(e.tim));
      check("rgb_cut",  32'(rgb_c), 32'(e.rgb_c));
      check("rgb_fade", 32'(rgb_f), 32'(e.rgb_f));
    end
  endtask

  task automatic step_idle();
    step(1'b0, 2'd0, 1'b0, 3'd0);
  endtask

  task automatic run_to(input int p);
    while (gpos != p) step_idle();
  endtask

  task automatic run_frames(input int n);
    repeat (n * 128) step_idle();
  endtask

  // Walks n vblank ticks of a fade, optionally retargeting during fade-out.
  task automatic fade_seq(input int fin, input int start, input bit mid, input logic [2:0] mid_idx, input int n);
    for (int k = 0; k < n; k++) begin
      run_to(96);
      check("busy_pre_tick", 32'(busy_f), 32'(1));
      step_idle();
      check("busy_post_tick", 32'(busy_f), 32'((k == 7) ? 0 : 1));
      check("active_fade", 32'(act_f), 32'((k >= 3) ? fin : start));
      exp_lvl_f = lvls[k];
      exp_scr_f = (k >= 3) ? fin : start;
      if (mid && k == 1) begin
        run_to(40);
        step(1'b0, 2'd0, 1'b1, mid_idx);
      end
    end
  endtask

  task automatic release_reset();
    sb.delete();
    gpos = 0;
    exp_scr_c = 0;
    exp_scr_f = 0;
    exp_lvl_f = 16;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rgb_in = {12'h3C7, 12'h0A5, 12'h888, 12'hF00};
    {hc_in, vc_in, hs_in, vs_in, hb_in, vb_in} = '0;
    req_c = '0; val_c = 1'b0; req_f = '0; val_f = 1'b0;
    exp_scr_c = 0; exp_scr_f = 0; exp_lvl_f = 16;
    repeat (3) @(negedge pclk);
    check("reset_out_cut",  32'({rgb_c, hco_c, busy_c, err_c}), 32'(0));
    check("reset_out_fade", 32'({rgb_f, vco_f, busy_f, err_f}), 32'(0));
    check("reset_active",   32'({act_c, act_f}), 32'(0));
    release_reset();

    // Passthrough, blanking and two-cycle timing delay.
    run_frames(2);

    // Hard cut: busy next cycle, switch only at vblank rise.
    run_to(40);
    step(1'b1, 2'd2, 1'b0, 3'd0);
    check("cut_busy_next", 32'(busy_c), 32'(1));
    check("cut_act_hold",  32'(act_c), 32'(0));
    run_to(96);
    check("cut_act_preframe", 32'(act_c), 32'(0));
    step_idle();
    check("cut_act_switched", 32'(act_c), 32'(2));
    check("cut_busy_done",    32'(busy_c), 32'(0));
    exp_scr_c = 2;
    run_to(0);
    run_frames(1);

    // Fade 0 -> 1 with ch0 white and ch1 grey.
    rgb_in[11:0] = 12'hFFF;
    run_to(40);
    step(1'b0, 2'd0, 1'b1, 3'd1);
    check("fade_busy_next", 32'(busy_f), 32'(1));
    fade_seq(1, 0, 1'b0, 3'd0, 8);
    run_to(0);
    run_frames(1);

    // Retarget during fade-out: single fade ends on screen 3.
    run_to(40);
    step(1'b0, 2'd0, 1'b1, 3'd2);
    fade_seq(3, 1, 1'b1, 3'd3, 8);
    run_to(0);
    run_frames(1);

    // Out-of-range request pulses req_error and changes nothing.
    run_to(40);
    step(1'b0, 2'd0, 1'b1, 3'd5);
    check("err_pulse",    32'(err_f), 32'(1));
    check("err_no_busy",  32'(busy_f), 32'(0));
    step_idle();
    check("err_one_cycle", 32'(err_f), 32'(0));
    check("err_act_kept",  32'(act_f), 32'(3));
    check("err_cut_quiet", 32'(err_c), 32'(0));
    run_to(0);
    run_frames(1);

    // Request landing on the vblank-rise cycle switches one frame later.
    run_to(96);
    step(1'b1, 2'd1, 1'b0, 3'd0);
    check("tick_req_act",  32'(act_c), 32'(2));
    check("tick_req_busy", 32'(busy_c), 32'(1));
    run_to(96);
    step_idle();
    check("tick_req_switched", 32'(act_c), 32'(1));
    exp_scr_c = 1;
    run_to(0);
    run_frames(1);

    // Async reset in the middle of a fade-in.
    run_to(40);
    step(1'b0, 2'd0, 1'b1, 3'd1);
    fade_seq(1, 3, 1'b0, 3'd0, 5);
    run_to(40);
    rst = 1'b1;
    #1;
    check("async_rst_rgb",    32'({rgb_c, rgb_f}), 32'(0));
    check("async_rst_timing", 32'({hco_f, vco_f, hso_f, vso_f, hbo_f, vbo_f}), 32'(0));
    check("async_rst_state",  32'({act_c, act_f, busy_f}), 32'(0));
    @(negedge pclk);
    release_reset();
    run_frames(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
